// File: rtl/pipeline_hazard_controller.sv
// Central hazard sequencer for the 5-stage pipeline.
// Produces per-stage load enables, bubble/flush requests and the PC source
// select. Hazard priority: data-memory wait > taken redirect > load-use.
// Saturating stall/flush counters are kept for performance debug.
module pipeline_hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_memRead,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_mem_memAccess,
    input  logic             mem_ready,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_jump,
    input  logic             err_clear,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       pc_sel,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrlState_t;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrlState_t      state;
    ctrlState_t      nextState;
    logic [TO_W-1:0] waitCnt;
    logic [TO_W-1:0] nextWaitCnt;
    logic            memWait;
    logic            redirect;
    logic            loadUse;
    logic            redirTaken;

    // Hazard detection terms, evaluated from the current pipeline contents.
    assign memWait  = ex_mem_memAccess & ~mem_ready;
    assign redirect = (ex_mem_branch & ex_mem_zero) | ex_mem_jump;
    assign loadUse  = id_ex_memRead & (id_ex_rd != 5'd0) &
                      ((id_ex_rd == if_id_rs) | (if_id_uses_rt & (id_ex_rd == if_id_rt)));

    // Next-state and same-cycle pipeline control outputs.
    // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = 2'd0;
        nextState    = state;
        nextWaitCnt  = waitCnt;
        redirTaken   = 1'b0;

        if (rst) begin
            // Hold every stage and inject bubbles while reset is asserted.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            nextState    = RUN;
            nextWaitCnt  = '0;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (memWait) begin
                        // Freeze everything; a pending redirect is retried once
                        // the held EX_MEM access completes.
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                        if (waitCnt == WAIT_LAST) begin
                            nextState   = ERROR;
                            nextWaitCnt = '0;
                        end else begin
                            nextState   = MEM_WAIT;
                            nextWaitCnt = waitCnt + TO_W'(1);
                        end
                    end else begin
                        nextState   = RUN;
                        nextWaitCnt = '0;
                        if (redirect) begin
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                            pc_sel       = ex_mem_jump ? 2'd2 : 2'd1;
                            redirTaken   = 1'b1;
                        end else if (loadUse) begin
                            // One bubble: hold PC/IF_ID, insert NOP into ID_EX.
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                ERROR: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_en    = 1'b0;
                    ex_mem_en   = 1'b0;
                    mem_wb_en   = 1'b0;
                    nextWaitCnt = '0;
                    if (err_clear) begin
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState   = RUN;
                    nextWaitCnt = '0;
                end
            endcase
        end
    end

    // State, wait counter, error flag and saturating performance counters.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            waitCnt     <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= nextState;
            waitCnt   <= nextWaitCnt;
            mem_error <= (nextState == ERROR);
            if (!pc_en && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (redirTaken && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int CNT_W       = 6;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 7;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             if_id_uses_rt;
    logic             id_ex_memRead;
    logic [4:0]       id_ex_rd;
    logic             ex_mem_memAccess;
    logic             mem_ready;
    logic             ex_mem_branch;
    logic             ex_mem_zero;
    logic             ex_mem_jump;
    logic             err_clear;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [1:0]       pc_sel;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: consecutive memory-wait cycles, error flag, counters.
    int mWaitRun = 0;
    bit mErr     = 1'b0;
    int mStall   = 0;
    int mFlush   = 0;

    pipeline_hazard_controller #(
        .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rd(id_ex_rd),
        .ex_mem_memAccess(ex_mem_memAccess), .mem_ready(mem_ready),
        .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero), .ex_mem_jump(ex_mem_jump),
        .err_clear(err_clear),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .pc_sel(pc_sel), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst              = 1'b0;
        if_id_rs         = 5'd0;
        if_id_rt         = 5'd0;
        if_id_uses_rt    = 1'b0;
        id_ex_memRead    = 1'b0;
        id_ex_rd         = 5'd0;
        ex_mem_memAccess = 1'b0;
        mem_ready        = 1'b0;
        ex_mem_branch    = 1'b0;
        ex_mem_zero      = 1'b0;
        ex_mem_jump      = 1'b0;
        err_clear        = 1'b0;
    endtask

    // One clock cycle: inputs already driven just after the previous edge.
    // Checks combinational controls mid-cycle, then registered state after the edge.
    task automatic tick();
        logic [4:0] expEn;
        logic [2:0] expFl;
        logic [1:0] expSel;
        bit mw, rd, lu, applied;
        #3;
        mw = ex_mem_memAccess && !mem_ready;
        rd = (ex_mem_branch && ex_mem_zero) || ex_mem_jump;
        lu = id_ex_memRead && (id_ex_rd != 5'd0) &&
             ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));
        applied = 1'b0;
        expSel  = 2'd0;
        if (rst) begin
            expEn = 5'b00000; expFl = 3'b111;
        end else if (mErr || mw) begin
            expEn = 5'b00000; expFl = 3'b000;
        end else if (rd) begin
            expEn = 5'b11111; expFl = 3'b111;
            expSel = ex_mem_jump ? 2'd2 : 2'd1;
            applied = 1'b1;
        end else if (lu) begin
            expEn = 5'b00111; expFl = 3'b010;
        end else begin
            expEn = 5'b11111; expFl = 3'b000;
        end
        check("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, expEn});
        check("flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, {29'd0, expFl});
        check("pc_sel", {30'd0, pc_sel}, {30'd0, expSel});

        @(posedge clk);
        #1;
        if (rst) begin
            mWaitRun = 0; mErr = 1'b0; mStall = 0; mFlush = 0;
        end else begin
            if (expEn[4] == 1'b0 && mStall < CNT_MAX) mStall++;
            if (applied && mFlush < CNT_MAX) mFlush++;
            if (mErr) begin
                if (err_clear) mErr = 1'b0;
            end else if (mw) begin
                mWaitRun++;
                if (mWaitRun == MEM_TIMEOUT) begin
                    mErr = 1'b1;
                    mWaitRun = 0;
                end
            end else begin
                mWaitRun = 0;
            end
        end
        check("mem_error", {31'd0, mem_error}, {31'd0, mErr});
        check("stall_count", {26'd0, stall_count}, mStall);
        check("flush_count", {26'd0, flush_count}, mFlush);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset held: forced outputs, counters clear.
        tick();

        // Load-use on rs: exactly one bubble, then normal.
        idle(); id_ex_memRead = 1'b1; id_ex_rd = 5'd5; if_id_rs = 5'd5; tick();
        check("lu_stall_count", {26'd0, stall_count}, 32'd1);
        idle(); tick();

        // No false stall: rd = 0, and rt match without uses_rt.
        idle(); id_ex_memRead = 1'b1; id_ex_rd = 5'd0; if_id_rs = 5'd0; tick();
        idle(); id_ex_memRead = 1'b1; id_ex_rd = 5'd7; if_id_rt = 5'd7; if_id_rs = 5'd1; tick();
        // rt match with uses_rt set does stall.
        idle(); id_ex_memRead = 1'b1; id_ex_rd = 5'd7; if_id_rt = 5'd7; if_id_uses_rt = 1'b1; tick();

        // Branch taken, then branch+jump (jump wins), then redirect over load-use.
        idle(); ex_mem_branch = 1'b1; ex_mem_zero = 1'b1; tick();
        check("branch_flush_count", {26'd0, flush_count}, 32'd1);
        idle(); ex_mem_branch = 1'b1; ex_mem_zero = 1'b1; ex_mem_jump = 1'b1; tick();
        idle(); ex_mem_branch = 1'b1; ex_mem_zero = 1'b0; tick();
        idle(); ex_mem_jump = 1'b1; id_ex_memRead = 1'b1; id_ex_rd = 5'd3; if_id_rs = 5'd3; tick();

        // Memory wait: 3 frozen cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            idle(); ex_mem_memAccess = 1'b1; tick();
        end
        idle(); ex_mem_memAccess = 1'b1; mem_ready = 1'b1; tick();
        // Memory wait with a pending branch: redirect only on the ready cycle.
        for (int i = 0; i < 2; i++) begin
            idle(); ex_mem_memAccess = 1'b1; ex_mem_branch = 1'b1; ex_mem_zero = 1'b1; tick();
        end
        idle(); ex_mem_memAccess = 1'b1; mem_ready = 1'b1; ex_mem_branch = 1'b1; ex_mem_zero = 1'b1; tick();

        // Timeout into ERROR, linger, then clear.
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) begin
            idle(); ex_mem_memAccess = 1'b1; tick();
        end
        check("timeout_error", {31'd0, mem_error}, 32'd1);
        idle(); err_clear = 1'b1; tick();
        check("error_cleared", {31'd0, mem_error}, 32'd0);
        idle(); tick();

        // Drive both counters to saturation.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            idle(); ex_mem_memAccess = 1'b1; tick();
        end
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            idle(); tick();
        end
        check("stall_saturated", {26'd0, stall_count}, CNT_MAX);
        idle(); err_clear = 1'b1; tick();
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            idle(); ex_mem_jump = 1'b1; tick();
        end
        check("flush_saturated", {26'd0, flush_count}, CNT_MAX);

        // Reset in the middle of a memory wait.
        for (int i = 0; i < 2; i++) begin
            idle(); ex_mem_memAccess = 1'b1; tick();
        end
        idle(); ex_mem_memAccess = 1'b1; rst = 1'b1; tick();
        check("reset_stall_clear", {26'd0, stall_count}, 32'd0);
        idle(); tick();

        // Randomized traffic in blocks: memory-stall-heavy or general mix.
        for (int blk = 0; blk < 40; blk++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int c = 0; c < 10; c++) begin
                idle();
                rst              = ($urandom_range(0, 63) == 0);
                err_clear        = ($urandom_range(0, 5) == 0);
                if_id_rs         = 5'($urandom_range(0, 3));
                if_id_rt         = 5'($urandom_range(0, 3));
                if_id_uses_rt    = 1'($urandom_range(0, 1));
                id_ex_memRead    = 1'($urandom_range(0, 1));
                id_ex_rd         = 5'($urandom_range(0, 3));
                ex_mem_branch    = ($urandom_range(0, 3) == 0);
                ex_mem_zero      = 1'($urandom_range(0, 1));
                ex_mem_jump      = ($urandom_range(0, 7) == 0);
                if (mode == 0) begin
                    ex_mem_memAccess = 1'b1;
                    mem_ready        = ($urandom_range(0, 4) == 0);
                end else begin
                    ex_mem_memAccess = ($urandom_range(0, 2) == 0);
                    mem_ready        = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
